// File: rtl/tx_serializer_if.sv
// Scheduler-to-serializer TX channel: command handshake, payload pull,
// progress reporting, reply-start notification and the serial pins.
interface tx_serializer_if #(
    parameter int NSHIFT         = 2,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int TX_CMD_BITS    = 4
) ();
    localparam int CNT_W = $clog2(PAYLOAD_CYCLES) + 1;

    logic                   tx_command_valid;
    logic [TX_CMD_BITS-1:0] tx_command;
    logic                   tx_reply_wanted;
    logic                   tx_command_started;
    logic                   tx_active;
    logic [NSHIFT-1:0]      tx_data;
    logic                   tx_data_next;
    logic [CNT_W-1:0]       tx_counter;
    logic                   tx_done;
    logic                   rx_started;
    logic                   tx_busy;
    logic [NSHIFT-1:0]      tx_pins;

    // Scheduler / environment side
    modport master (
        output tx_command_valid, tx_command, tx_reply_wanted, tx_data, rx_started,
        input  tx_command_started, tx_active, tx_data_next, tx_counter, tx_done,
               tx_busy, tx_pins
    );

    // Serializer side
    modport slave (
        input  tx_command_valid, tx_command, tx_reply_wanted, tx_data, rx_started,
        output tx_command_started, tx_active, tx_data_next, tx_counter, tx_done,
               tx_busy, tx_pins
    );
endinterface

// File: rtl/tx_serializer.sv
// TX frame serializer: start chunk, command chunks LSB first, then payload
// chunks pulled from the scheduler; optionally holds until the RX reply starts.
module tx_serializer #(
    parameter int NSHIFT         = 2,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int TX_CMD_BITS    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    tx_serializer_if.slave    tx
);
    localparam int CNT_W      = $clog2(PAYLOAD_CYCLES) + 1;
    localparam int CMD_CHUNKS = TX_CMD_BITS / NSHIFT;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_CHUNKS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_CMD        = 3'd2,
        ST_DATA       = 3'd3,
        ST_WAIT_REPLY = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [TX_CMD_BITS-1:0] cmd_r;
    logic                   reply_r;
    logic [CNT_W-1:0]       count_r;

    logic accept_s;
    logic cmd_last_s;
    logic data_last_s;

    // Accept and end-of-phase decodes shared by the FSM and the datapath
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && tx.tx_command_valid && rst_n;
        cmd_last_s  = (state_r == ST_CMD)  && (count_r == CMD_LAST);
        data_last_s = (state_r == ST_DATA) && (count_r == DATA_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt_s = ST_CMD;
            end
            ST_CMD: begin
                if (cmd_last_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_CMD;
                end
            end
            ST_DATA: begin
                // rx_started is not looked at here, so a pulse coincident with tx_done is dropped
                if (data_last_s && reply_r) begin
                    state_nxt_s = ST_WAIT_REPLY;
                end else if (data_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_WAIT_REPLY: begin
                if (tx.rx_started) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_REPLY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Command shift register, reply flag and chunk counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_r   <= {TX_CMD_BITS{1'b0}};
            reply_r <= 1'b0;
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_r   <= tx.tx_command;
                        reply_r <= tx.tx_reply_wanted;
                    end else begin
                        cmd_r   <= cmd_r;
                        reply_r <= reply_r;
                    end
                    count_r <= {CNT_W{1'b0}};
                end
                ST_START: begin
                    count_r <= {CNT_W{1'b0}};
                end
                ST_CMD: begin
                    cmd_r <= cmd_r >> NSHIFT;
                    if (cmd_last_s) begin
                        count_r <= {CNT_W{1'b0}};
                    end else begin
                        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DATA: begin
                    if (data_last_s) begin
                        count_r <= {CNT_W{1'b0}};
                    end else begin
                        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_WAIT_REPLY: begin
                    if (tx.rx_started) begin
                        reply_r <= 1'b0;
                    end else begin
                        reply_r <= reply_r;
                    end
                    count_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cmd_r   <= {TX_CMD_BITS{1'b0}};
                    reply_r <= 1'b0;
                    count_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode; pins idle high, payload passes straight through in DATA
    always_comb begin
        tx.tx_command_started = accept_s;
        tx.tx_pins            = {NSHIFT{1'b1}};
        tx.tx_active          = 1'b0;
        tx.tx_data_next       = 1'b0;
        tx.tx_counter         = {CNT_W{1'b0}};
        tx.tx_done            = 1'b0;
        tx.tx_busy            = 1'b1;
        case (state_r)
            ST_IDLE: begin
                tx.tx_busy = 1'b0;
            end
            ST_START: begin
                tx.tx_pins   = {NSHIFT{1'b0}};
                tx.tx_active = 1'b1;
            end
            ST_CMD: begin
                tx.tx_pins   = cmd_r[NSHIFT-1:0];
                tx.tx_active = 1'b1;
            end
            ST_DATA: begin
                tx.tx_pins      = tx.tx_data;
                tx.tx_active    = 1'b1;
                tx.tx_data_next = 1'b1;
                tx.tx_counter   = count_r;
                tx.tx_done      = data_last_s;
            end
            ST_WAIT_REPLY: begin
                tx.tx_pins = {NSHIFT{1'b1}};
            end
            default: begin
                tx.tx_pins = {NSHIFT{1'b1}};
            end
        endcase
    end
endmodule

// File: tb/tb_tx_serializer.sv
// Randomized bench for tx_serializer against a frame-position reference model.
module tb_tx_serializer;
    localparam int NSHIFT         = 2;
    localparam int PAYLOAD_CYCLES = 8;
    localparam int TX_CMD_BITS    = 4;
    localparam int CNT_W          = $clog2(PAYLOAD_CYCLES) + 1;
    localparam int CC             = TX_CMD_BITS / NSHIFT;
    localparam int FL             = 1 + CC + PAYLOAD_CYCLES;
    localparam int POS_WAIT       = FL + 1;

    logic clk;
    logic rst_n;

    tx_serializer_if #(
        .NSHIFT(NSHIFT), .PAYLOAD_CYCLES(PAYLOAD_CYCLES), .TX_CMD_BITS(TX_CMD_BITS)
    ) bus ();

    tx_serializer #(
        .NSHIFT(NSHIFT), .PAYLOAD_CYCLES(PAYLOAD_CYCLES), .TX_CMD_BITS(TX_CMD_BITS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tx   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model: position within the frame (0 idle, 1..FL on the wire, POS_WAIT waiting)
    int                     pos = 0;
    logic                   m_rep = 1'b0;
    logic [TX_CMD_BITS-1:0] m_cmd = '0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (pos %0d, t=%0t)", tag, act, exp, pos, $time);
        end
    endtask

    task automatic step(input logic v, input logic [TX_CMD_BITS-1:0] c, input logic r,
                        input logic rx, input logic rs, input bit chk);
        logic [NSHIFT-1:0] d;
        logic [NSHIFT-1:0] e_pins;
        logic [CNT_W-1:0]  e_cnt;
        logic e_started, e_active, e_next, e_done, e_busy;
        int idx;
        @(negedge clk);
        d = NSHIFT'($urandom);
        bus.tx_command_valid = v;
        bus.tx_command       = c;
        bus.tx_reply_wanted  = r;
        bus.tx_data          = d;
        bus.rx_started       = rx;
        rst_n                = rs;
        #1;
        e_pins = {NSHIFT{1'b1}};
        e_cnt = '0; e_started = 1'b0; e_active = 1'b0; e_next = 1'b0; e_done = 1'b0; e_busy = 1'b1;
        if (pos == 0) begin
            e_busy = 1'b0;
            e_started = v && rs;
        end else if (pos == 1) begin
            e_pins = '0; e_active = 1'b1;
        end else if (pos <= 1 + CC) begin
            e_pins = NSHIFT'(m_cmd >> (NSHIFT * (pos - 2)));
            e_active = 1'b1;
        end else if (pos <= FL) begin
            idx = pos - 2 - CC;
            e_pins = d; e_active = 1'b1; e_next = 1'b1;
            e_cnt = CNT_W'(idx);
            e_done = (idx == PAYLOAD_CYCLES - 1);
        end
        if (chk) begin
            check_val("started", bus.tx_command_started, e_started);
            check_val("pins",    bus.tx_pins,            e_pins);
            check_val("active",  bus.tx_active,          e_active);
            check_val("next",    bus.tx_data_next,       e_next);
            check_val("counter", bus.tx_counter,         e_cnt);
            check_val("done",    bus.tx_done,            e_done);
            check_val("busy",    bus.tx_busy,            e_busy);
        end
        // advance model to the state after the coming posedge
        if (!rs) begin
            pos = 0; m_rep = 1'b0; m_cmd = '0;
        end else if (pos == 0) begin
            if (v) begin
                pos = 1; m_cmd = c; m_rep = r;
            end
        end else if (pos < FL) begin
            pos++;
        end else if (pos == FL) begin
            pos = m_rep ? POS_WAIT : 0;
        end else if (rx) begin
            pos = 0; m_rep = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tx_command_valid = 1'b0;
        bus.tx_command = '0;
        bus.tx_reply_wanted = 1'b0;
        bus.tx_data = '0;
        bus.rx_started = 1'b0;

        // reset then idle
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // single frame cmd=1001, no reply; command changes after accept are ignored
        step(1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b0, 4'(i), 1'b1, 1'b0, 1'b1, 1'b1);

        // valid held high: accepts spaced FL+1 cycles apart
        for (int i = 0; i < 3 * (FL + 1); i++)
            step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // reply wanted: rx_started coincident with tx_done is ignored, later pulse releases
        step(1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < FL; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // reset in the middle of DATA, then a normal frame
        step(1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 6; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < FL + 1; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) != 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
